axi_read_arbiter: RTL and testbench

// - Shares the single AXI4 master read port (AR/R) between NREQ read requesters: req 0 = icache refill, req 1 = LSU load.
// - Round-robin grant; one transaction in flight at a time; supports bursts (arlen>0) terminated by rlast.
// - Sits between the fetch/LSU units and the SoC-facing io_master_* read channel; arid carries the granted index.

---
 rtl/axi_read_arbiter.sv | 152 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI4 master read port (AR/R) between NREQ requesters.
// Requester 0 is the icache refill path and requester 1 is the LSU load path.
// Arbitration is round-robin, and only one transaction is in flight at a time.
// Bursts end on rlast. The R channel is a zero-latency pass-through to the granted requester.
module axi_read_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_arvalid,
   output logic [NREQ-1:0]        req_arready,
   input  logic [NREQ*ADDR_W-1:0] req_araddr,
   input  logic [NREQ*8-1:0]      req_arlen,
   input  logic [NREQ*3-1:0]      req_arsize,
   output logic [NREQ-1:0]        req_rvalid,
   input  logic [NREQ-1:0]        req_rready,
   output logic [63:0]            req_rdata,
   output logic [1:0]             req_rresp,
   output logic                   req_rlast,
   input  logic                   io_master_arready,
   output logic                   io_master_arvalid,
   output logic [ADDR_W-1:0]      io_master_araddr,
   output logic [3:0]             io_master_arid,
   output logic [7:0]             io_master_arlen,
   output logic [2:0]             io_master_arsize,
   output logic [1:0]             io_master_arburst,
   output logic                   io_master_rready,
   input  logic                   io_master_rvalid,
   input  logic [1:0]             io_master_rresp,
   input  logic [63:0]            io_master_rdata,
   input  logic                   io_master_rlast,
   input  logic [3:0]             io_master_rid
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t              state;
   logic [GW-1:0]       grant;
   logic [GW-1:0]       last;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;

   logic [GW-1:0]       winner;
   logic                winner_found;
   logic                in_addr;
   logic                in_data;
   logic                beat_done;

   assign in_addr   = (state == ADDR);
   assign in_data   = (state == DATA);
   assign beat_done = in_data && io_master_rvalid && io_master_rready && io_master_rlast;

   // Search from the requester after the last one served, so the most recent winner has the lowest priority.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!winner_found && req_arvalid[(int'(last) + k) % NREQ]) begin
            winner_found = 1'b1;
            winner       = GW'((int'(last) + k) % NREQ);
         end
      end
   end

   // Accept the winner combinationally in IDLE. The output is held at zero while reset is asserted.
   always_comb begin
      req_arready = '0;
      if (reset && state == IDLE && winner_found) begin
         req_arready[winner] = 1'b1;
      end
   end

   // Drive the downstream AR fields only while the address is being presented, so the bus is quiet otherwise.
   always_comb begin
      io_master_arvalid = in_addr;
      io_master_araddr  = in_addr ? addr_q : '0;
      io_master_arid    = in_addr ? 4'(grant) : 4'd0;
      io_master_arlen   = in_addr ? len_q : 8'd0;
      io_master_arsize  = in_addr ? size_q : 3'd0;
      io_master_arburst = in_addr ? 2'b01 : 2'b00;
   end

   // Route R beats to the granted requester only. Beats seen outside DATA are neither accepted nor forwarded.
   always_comb begin
      req_rvalid       = '0;
      io_master_rready = 1'b0;
      req_rdata        = '0;
      req_rresp        = '0;
      req_rlast        = 1'b0;
      if (in_data) begin
         req_rvalid[grant] = io_master_rvalid;
         io_master_rready  = req_rready[grant];
         req_rdata         = io_master_rdata;
         req_rresp         = io_master_rresp;
         req_rlast         = io_master_rlast;
      end
   end

   // Transaction FSM: latch the winner's request, present it on AR, then stay until the rlast beat completes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         grant  <= '0;
         last   <= GW'(NREQ - 1);
         addr_q <= '0;
         len_q  <= '0;
         size_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (winner_found) begin
                  grant  <= winner;
                  addr_q <= req_araddr[ADDR_W*winner +: ADDR_W];
                  len_q  <= req_arlen[8*winner +: 8];
                  size_q <= req_arsize[3*winner +: 3];
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (io_master_arready) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (beat_done) begin
                  last  <= grant;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A beat carrying an id other than the grant indicates a broken downstream. Hardware still routes it to grant.
   always @(posedge clock) begin
      if (reset && in_data && io_master_rvalid) begin
         assert (io_master_rid == 4'(grant))
            else $fatal(1, "axi_read_arbiter: rid %0d does not match grant %0d", io_master_rid, grant);
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
// Directed bench for axi_read_arbiter with two requesters.
// Expected values are hand-computed from the arbitration and handshake rules.
module tb_axi_read_arbiter;

   logic          clock;
   logic          reset;
   logic [1:0]    req_arvalid;
   logic [1:0]    req_arready;
   logic [63:0]   req_araddr;
   logic [15:0]   req_arlen;
   logic [5:0]    req_arsize;
   logic [1:0]    req_rvalid;
   logic [1:0]    req_rready;
   logic [63:0]   req_rdata;
   logic [1:0]    req_rresp;
   logic          req_rlast;
   logic          io_master_arready;
   logic          io_master_arvalid;
   logic [31:0]   io_master_araddr;
   logic [3:0]    io_master_arid;
   logic [7:0]    io_master_arlen;
   logic [2:0]    io_master_arsize;
   logic [1:0]    io_master_arburst;
   logic          io_master_rready;
   logic          io_master_rvalid;
   logic [1:0]    io_master_rresp;
   logic [63:0]   io_master_rdata;
   logic          io_master_rlast;
   logic [3:0]    io_master_rid;

   int total;
   int bad;

   axi_read_arbiter #(.NREQ(2), .ADDR_W(32)) dut (
      .clock             (clock),
      .reset             (reset),
      .req_arvalid       (req_arvalid),
      .req_arready       (req_arready),
      .req_araddr        (req_araddr),
      .req_arlen         (req_arlen),
      .req_arsize        (req_arsize),
      .req_rvalid        (req_rvalid),
      .req_rready        (req_rready),
      .req_rdata         (req_rdata),
      .req_rresp         (req_rresp),
      .req_rlast         (req_rlast),
      .io_master_arready (io_master_arready),
      .io_master_arvalid (io_master_arvalid),
      .io_master_araddr  (io_master_araddr),
      .io_master_arid    (io_master_arid),
      .io_master_arlen   (io_master_arlen),
      .io_master_arsize  (io_master_arsize),
      .io_master_arburst (io_master_arburst),
      .io_master_rready  (io_master_rready),
      .io_master_rvalid  (io_master_rvalid),
      .io_master_rresp   (io_master_rresp),
      .io_master_rdata   (io_master_rdata),
      .io_master_rlast   (io_master_rlast),
      .io_master_rid     (io_master_rid)
   );

   // 10 ns clock with posedges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
         else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         end
   endtask

   // Drives one downstream R beat.
   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic l,
                                input logic [3:0] id, input logic [1:0] resp);
      io_master_rvalid = v;
      io_master_rdata  = d;
      io_master_rlast  = l;
      io_master_rid    = id;
      io_master_rresp  = resp;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_arready"}, req_arready, 2'b00);
      checkOutput({tag, "_arvalid"}, io_master_arvalid, 1'b0);
      checkOutput({tag, "_rvalid"}, req_rvalid, 2'b00);
      checkOutput({tag, "_rready"}, io_master_rready, 1'b0);
      checkOutput({tag, "_araddr"}, io_master_araddr, 32'h0);
      checkOutput({tag, "_arburst"}, io_master_arburst, 2'b00);
      checkOutput({tag, "_rdata"}, req_rdata, 64'h0);
   endtask

   initial begin
      int lastModel;
      int expGrant;
      int beat;
      logic rr;
      logic [1:0] expOh;

      total = 0;
      bad   = 0;
      reset = 1'b0;
      req_arvalid = 2'b00;
      req_araddr  = '0;
      req_arlen   = '0;
      req_arsize  = '0;
      req_rready  = 2'b00;
      io_master_arready = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0, 4'd0, 2'b00);

      // Reset held: every output is zero, even with a request pending.
      #3;
      req_arvalid = 2'b01;
      #1;
      checkQuiet("reset_hold");
      req_arvalid = 2'b00;
      @(negedge clock);
      reset = 1'b1;
      tick();
      checkQuiet("post_reset");
      lastModel = 1;

      // Single icache read.
      req_arvalid = 2'b01;
      req_araddr[31:0] = 32'h8000_0004;
      req_arlen[7:0]   = 8'd0;
      req_arsize[2:0]  = 3'd3;
      #1;
      checkOutput("single_arready", req_arready, 2'b01);
      tick();
      req_arvalid = 2'b00;
      #1;
      checkOutput("single_arready_addr", req_arready, 2'b00);
      checkOutput("single_arvalid", io_master_arvalid, 1'b1);
      checkOutput("single_araddr", io_master_araddr, 32'h8000_0004);
      checkOutput("single_arid", io_master_arid, 4'd0);
      checkOutput("single_arlen", io_master_arlen, 8'd0);
      checkOutput("single_arsize", io_master_arsize, 3'd3);
      checkOutput("single_arburst", io_master_arburst, 2'b01);
      io_master_arready = 1'b1;
      tick();
      io_master_arready = 1'b0;
      checkOutput("single_arvalid_drop", io_master_arvalid, 1'b0);
      req_rready = 2'b01;
      applyStimulus(1'b1, 64'h1122_3344_5566_7788, 1'b1, 4'd0, 2'b00);
      #1;
      checkOutput("single_rvalid", req_rvalid, 2'b01);
      checkOutput("single_rdata", req_rdata, 64'h1122_3344_5566_7788);
      checkOutput("single_rlast", req_rlast, 1'b1);
      checkOutput("single_rready", io_master_rready, 1'b1);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0, 4'd0, 2'b00);
      #1;
      checkOutput("single_idle_rvalid", req_rvalid, 2'b00);
      lastModel = 0;

      // Contention: both requesters request continuously, so the grant alternates away from the last winner.
      req_arvalid = 2'b11;
      req_araddr  = {32'h0000_2000, 32'h0000_1000};
      req_arlen   = 16'h0000;
      req_rready  = 2'b11;
      for (int t = 0; t < 4; t++) begin
         expGrant = (lastModel == 0) ? 1 : 0;
         expOh    = (expGrant == 1) ? 2'b10 : 2'b01;
         #1;
         checkOutput("cont_arready", req_arready, expOh);
         tick();
         checkOutput("cont_arid", io_master_arid, 4'(expGrant));
         checkOutput("cont_araddr", io_master_araddr, (expGrant == 1) ? 32'h2000 : 32'h1000);
         checkOutput("cont_arready_busy", req_arready, 2'b00);
         io_master_arready = 1'b1;
         tick();
         io_master_arready = 1'b0;
         applyStimulus(1'b1, 64'(t + 100), 1'b1, 4'(expGrant), 2'b00);
         #1;
         checkOutput("cont_rvalid", req_rvalid, expOh);
         tick();
         applyStimulus(1'b0, 64'h0, 1'b0, 4'd0, 2'b00);
         lastModel = expGrant;
      end
      req_arvalid = 2'b00;

      // LSU burst of 4 beats with toggling rready. The bench counts beats as they complete.
      tick();
      req_arvalid = 2'b10;
      req_araddr[63:32] = 32'h0000_3000;
      req_arlen[15:8]   = 8'd3;
      #1;
      checkOutput("burst_arready", req_arready, 2'b10);
      tick();
      req_arvalid = 2'b00;
      checkOutput("burst_arlen", io_master_arlen, 8'd3);
      checkOutput("burst_arid", io_master_arid, 4'd1);
      io_master_arready = 1'b1;
      tick();
      io_master_arready = 1'b0;
      beat = 0;
      for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
         rr = (cyc % 2 == 1);
         req_rready = {rr, 1'b0};
         applyStimulus(1'b1, 64'hB000 + 64'(beat), (beat == 3), 4'd1, (beat == 1) ? 2'b10 : 2'b00);
         #1;
         checkOutput("burst_rready", io_master_rready, rr);
         checkOutput("burst_rvalid", req_rvalid, 2'b10);
         checkOutput("burst_rdata", req_rdata, 64'hB000 + 64'(beat));
         checkOutput("burst_rresp", req_rresp, (beat == 1) ? 2'b10 : 2'b00);
         tick();
         if (rr) beat++;
      end
      checkOutput("burst_beats", 64'(beat), 64'd4);
      checkOutput("burst_done_rvalid", req_rvalid, 2'b00);
      checkOutput("burst_done_rready", io_master_rready, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b0, 4'd0, 2'b00);
      lastModel = 1;

      // AR back-pressure: the request is held stable for 5 cycles while a new request waits.
      req_arvalid = 2'b01;
      req_araddr[31:0] = 32'h0000_A000;
      req_arlen[7:0]   = 8'd2;
      #1;
      checkOutput("bp_arready", req_arready, 2'b01);
      tick();
      req_arvalid = 2'b11;
      for (int c = 0; c < 5; c++) begin
         #1;
         checkOutput("bp_arvalid", io_master_arvalid, 1'b1);
         checkOutput("bp_araddr", io_master_araddr, 32'h0000_A000);
         checkOutput("bp_arlen", io_master_arlen, 8'd2);
         checkOutput("bp_arid", io_master_arid, 4'd0);
         checkOutput("bp_req_arready", req_arready, 2'b00);
         tick();
      end
      io_master_arready = 1'b1;
      tick();
      io_master_arready = 1'b0;
      req_arvalid = 2'b00;

      // Async reset in the middle of the burst: outputs drop without a clock edge.
      req_rready = 2'b01;
      applyStimulus(1'b1, 64'hC0DE, 1'b0, 4'd0, 2'b00);
      #1;
      checkOutput("mid_rvalid", req_rvalid, 2'b01);
      tick();
      #1;
      checkOutput("mid_rvalid2", req_rvalid, 2'b01);
      reset = 1'b0;
      #1;
      checkOutput("async_rvalid", req_rvalid, 2'b00);
      checkOutput("async_rready", io_master_rready, 1'b0);
      checkOutput("async_rdata", req_rdata, 64'h0);
      applyStimulus(1'b0, 64'h0, 1'b0, 4'd0, 2'b00);
      @(negedge clock);
      reset = 1'b1;
      req_arvalid = 2'b11;
      #1;
      checkOutput("after_reset_arready", req_arready, 2'b01);
      tick();
      checkOutput("after_reset_arid", io_master_arid, 4'd0);
      req_arvalid = 2'b00;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
